// File: rtl/serial_alu_n.sv
// Bit-serial N-bit ALU: one one-bit-slice evaluation per clock, LSB first.
// Start/busy/done handshake; result, Cout and zero are held between completions.
module serial_alu_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             Cin,
  input  logic [2:0]       opsel,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             Cout,
  output logic             zero
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-2:0]   res_sh_q, res_sh_d;
  logic               carry_q, carry_d;
  logic [2:0]         op_q, op_d;
  logic               mode_q, mode_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               zero_q, zero_d;

  logic               accept;
  logic               last;
  logic [1:0]         bit_out;
  logic [WIDTH-1:0]   res_next;

  // One-bit slice: returns {carry_out, result_bit}. Carry out is 0 for logic and PASS A.
  function automatic logic [1:0] alu_bit(input logic a, input logic b, input logic c,
                                         input logic [2:0] op, input logic m);
    logic bp;
    logic [1:0] r;
    r  = 2'b00;
    bp = 1'b0;
    if (m) begin
      if (op[2]) begin
        r = {1'b0, a};
      end else begin
        case (op[1:0])
          2'b00:   bp = b;
          2'b01:   bp = ~b;
          2'b10:   bp = 1'b0;
          default: bp = 1'b1;
        endcase
        r = {(a & bp) | (a & c) | (bp & c), a ^ bp ^ c};
      end
    end else begin
      case (op)
        3'b000:  r = {1'b0, a & b};
        3'b001:  r = {1'b0, a | b};
        3'b010:  r = {1'b0, a ^ b};
        3'b011:  r = {1'b0, ~a};
        3'b100:  r = {1'b0, ~(a & b)};
        3'b101:  r = {1'b0, ~(a | b)};
        3'b110:  r = {1'b0, ~(a ^ b)};
        default: r = {1'b0, b};
      endcase
    end
    return r;
  endfunction

  // SUB and INC seed the chain with 1 (two's complement / +1); DEC adds all ones with 0.
  function automatic logic init_carry(input logic [2:0] op, input logic m, input logic cin);
    logic c;
    c = 1'b0;
    if (m) begin
      case (op)
        3'b000:        c = cin;
        3'b001, 3'b010: c = 1'b1;
        default:       c = 1'b0;
      endcase
    end
    return c;
  endfunction

  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last   = (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == S_RUN);
    done   = (state_q == S_DONE);
    result = result_q;
    Cout   = cout_q;
    zero   = zero_q;
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    op_d     = op_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    bit_out  = alu_bit(a_q[0], b_q[0], carry_q, op_q, mode_q);
    res_next = {bit_out[0], res_sh_q};
    if (accept) begin
      a_d      = op1;
      b_d      = op2;
      op_d     = opsel;
      mode_d   = mode;
      carry_d  = init_carry(opsel, mode, Cin);
      cnt_d    = '0;
      res_sh_d = '0;
    end else if (state_q == S_RUN) begin
      a_d      = a_q >> 1;
      b_d      = b_q >> 1;
      carry_d  = bit_out[1];
      res_sh_d = res_next[WIDTH-1:1];
      if (last) begin
        // Last slice: the full word is the new bit above the WIDTH-1 collected bits.
        result_d = res_next;
        cout_d   = bit_out[1];
        zero_d   = (res_next == '0);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      op_q     <= '0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_serial_alu_n.sv
// Scoreboard bench for serial_alu_n at WIDTH=8: expectations queued at issue, popped at done.
module tb_serial_alu_n;
  localparam int W = 8;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, Cin = 1'b0, mode = 1'b0;
  logic [W-1:0] op1 = '0, op2 = '0;
  logic [2:0]   opsel = '0;
  logic         busy, done, Cout, zero;
  logic [W-1:0] result;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         zero;
  } exp_t;

  exp_t sb_q[$];

  serial_alu_n #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op1(op1), .op2(op2), .Cin(Cin),
    .opsel(opsel), .mode(mode), .busy(busy), .done(done), .result(result),
    .Cout(Cout), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                 input logic [2:0] op, input logic m);
    logic [W:0] s;
    exp_t e;
    s = '0;
    if (m) begin
      case (op)
        3'b000:  s = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        3'b001:  s = {(a >= b), a - b};
        3'b010:  s = {1'b0, a} + (W+1)'(1);
        3'b011:  s = {(a != '0), a - W'(1)};
        default: s = {1'b0, a};
      endcase
    end else begin
      case (op)
        3'b000:  s = {1'b0, a & b};
        3'b001:  s = {1'b0, a | b};
        3'b010:  s = {1'b0, a ^ b};
        3'b011:  s = {1'b0, ~a};
        3'b100:  s = {1'b0, ~(a & b)};
        3'b101:  s = {1'b0, ~(a | b)};
        3'b110:  s = {1'b0, ~(a ^ b)};
        default: s = {1'b0, b};
      endcase
    end
    e.res  = s[W-1:0];
    e.cout = s[W];
    e.zero = (s[W-1:0] == '0);
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic [2:0] op, input logic m);
    op1 = a; op2 = b; Cin = cin; opsel = op; mode = m; start = 1'b1;
    sb_q.push_back(model(a, b, cin, op, m));
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== '0) begin failures++; $display("FAIL reset_result: got %h expected 00", result); end
    checks++; if (Cout !== 1'b0) begin failures++; $display("FAIL reset_cout: got %b expected 0", Cout); end
    checks++; if (zero !== 1'b0) begin failures++; $display("FAIL reset_zero: got %b expected 0", zero); end
    rst = 1'b0;
  endtask

  task automatic test_add_overflow();
    int lat, bcnt;
    exp_t e;
    @(negedge clk);
    issue(8'hFF, 8'h01, 1'b0, 3'b000, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL add_done_timeout: got done=%b expected 1", done); end
    checks++; if (lat != W) begin failures++; $display("FAIL add_latency: got %0d expected %0d", lat, W); end
    checks++; if (bcnt != W) begin failures++; $display("FAIL add_busy_cycles: got %0d expected %0d", bcnt, W); end
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    checks++; if (result !== e.res || result !== 8'h00) begin failures++; $display("FAIL add_result: got %h expected 00", result); end
    checks++; if (Cout !== 1'b1) begin failures++; $display("FAIL add_cout: got %b expected 1", Cout); end
    checks++; if (zero !== 1'b1) begin failures++; $display("FAIL add_zero: got %b expected 1", zero); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL add_done_pulse: got %b expected 0", done); end
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL add_hold: got %h expected 00", result); end
  endtask

  task automatic test_sub_dec();
    int lat, bcnt;
    exp_t e;
    logic [W-1:0] av [2] = '{8'h05, 8'h00};
    logic [W-1:0] bv [2] = '{8'h07, 8'h00};
    logic [2:0]   ov [2] = '{3'b001, 3'b011};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      issue(av[i], bv[i], 1'b1, ov[i], 1'b1);
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bcnt);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      checks++; if (done !== 1'b1 || result !== e.res) begin failures++; $display("FAIL subdec_result[%0d]: got %h done=%b expected %h", i, result, done, e.res); end
      checks++; if (Cout !== e.cout) begin failures++; $display("FAIL subdec_cout[%0d]: got %b expected %b", i, Cout, e.cout); end
      checks++; if (zero !== e.zero) begin failures++; $display("FAIL subdec_zero[%0d]: got %b expected %b", i, zero, e.zero); end
    end
  endtask

  task automatic test_logic_sweep();
    int lat, bcnt;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      issue(8'hC5, 8'h3A, 1'b1, 3'(i), 1'b0);
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bcnt);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      checks++; if (done !== 1'b1 || result !== e.res) begin failures++; $display("FAIL logic_result[%0d]: got %h done=%b expected %h", i, result, done, e.res); end
      checks++; if (Cout !== 1'b0 || zero !== e.zero) begin failures++; $display("FAIL logic_flags[%0d]: got cout=%b zero=%b expected cout=0 zero=%b", i, Cout, zero, e.zero); end
    end
  endtask

  task automatic test_arith_misc();
    int lat, bcnt;
    exp_t e;
    logic [W-1:0] a, b;
    logic [2:0]   op;
    logic         c;
    logic [W-1:0] fa [4] = '{8'hFF, 8'h3C, 8'h5A, 8'h80};
    logic [W-1:0] fb [4] = '{8'h12, 8'hC3, 8'h99, 8'h80};
    logic [2:0]   fo [4] = '{3'b010, 3'b000, 3'b110, 3'b001};
    for (int i = 0; i < 10; i++) begin
      if (i < 6) begin
        a = W'($urandom); b = W'($urandom); op = 3'($urandom_range(0, 3)); c = 1'($urandom);
      end else begin
        a = fa[i-6]; b = fb[i-6]; op = fo[i-6]; c = 1'b1;
      end
      @(negedge clk);
      issue(a, b, c, op, 1'b1);
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bcnt);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      checks++; if (done !== 1'b1 || result !== e.res) begin failures++; $display("FAIL arith_result[%0d]: got %h done=%b expected %h", i, result, done, e.res); end
      checks++; if (Cout !== e.cout || zero !== e.zero) begin failures++; $display("FAIL arith_flags[%0d]: got cout=%b zero=%b expected cout=%b zero=%b", i, Cout, zero, e.cout, e.zero); end
    end
  endtask

  task automatic test_start_ignored();
    int lat, bcnt, ndone;
    exp_t e;
    logic [W-1:0] prev;
    prev = result;
    @(negedge clk);
    issue(8'h11, 8'h22, 1'b0, 3'b000, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    op1 = 8'hAA; op2 = 8'h55; opsel = 3'b001; mode = 1'b0; Cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (result !== prev || busy !== 1'b1) begin failures++; $display("FAIL ignore_hold: got result=%h busy=%b expected %h busy=1", result, busy, prev); end
    wait_done(lat, bcnt);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    checks++; if (done !== 1'b1 || result !== e.res) begin failures++; $display("FAIL ignore_result: got %h done=%b expected %h", result, done, e.res); end
    checks++; if (Cout !== e.cout) begin failures++; $display("FAIL ignore_cout: got %b expected %b", Cout, e.cout); end
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin failures++; $display("FAIL ignore_extra_done: got %0d expected 0", ndone); end
  endtask

  task automatic test_back_to_back();
    int cyc, busy_err;
    exp_t e;
    logic [W-1:0] av [3] = '{8'h10, 8'h50, 8'hF0};
    logic [W-1:0] bv [3] = '{8'h20, 8'h20, 8'h0F};
    logic [2:0]   ov [3] = '{3'b000, 3'b001, 3'b010};
    logic         mv [3] = '{1'b1, 1'b1, 1'b0};
    busy_err = 0;
    @(negedge clk);
    issue(av[0], bv[0], 1'b1, ov[0], mv[0]);
    for (int i = 0; i < 3; i++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (busy === done) busy_err++;
      end while (done !== 1'b1 && cyc < 30);
      checks++; if (cyc != W + 1) begin failures++; $display("FAIL b2b_interval[%0d]: got %0d expected %0d", i, cyc, W + 1); end
      e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      checks++; if (done !== 1'b1 || result !== e.res || Cout !== e.cout) begin failures++; $display("FAIL b2b_result[%0d]: got %h/%b expected %h/%b", i, result, Cout, e.res, e.cout); end
      if (i < 2) issue(av[i+1], bv[i+1], 1'b1, ov[i+1], mv[i+1]);
      else start = 1'b0;
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_idle: got done=%b busy=%b expected 0 0", done, busy); end
    checks++; if (busy_err != 0) begin failures++; $display("FAIL b2b_busy_vs_done: got %0d cycles wrong expected 0", busy_err); end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, ndone;
    exp_t e;
    @(negedge clk);
    op1 = 8'h12; op2 = 8'h34; Cin = 1'b0; opsel = 3'b000; mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_ctrl: got busy=%b done=%b expected 0 0", busy, done); end
    checks++; if (result !== '0) begin failures++; $display("FAIL midrst_result: got %h expected 00", result); end
    checks++; if (Cout !== 1'b0 || zero !== 1'b0) begin failures++; $display("FAIL midrst_flags: got cout=%b zero=%b expected 0 0", Cout, zero); end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin failures++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", ndone); end
    issue(8'h7F, 8'h01, 1'b0, 3'b000, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    checks++; if (done !== 1'b1 || result !== e.res || result !== 8'h80) begin failures++; $display("FAIL midrst_fresh_result: got %h done=%b expected 80", result, done); end
    checks++; if (Cout !== 1'b0 || zero !== 1'b0) begin failures++; $display("FAIL midrst_fresh_flags: got cout=%b zero=%b expected 0 0", Cout, zero); end
    checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_dec();
    test_logic_sweep();
    test_arith_misc();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
